// File: rtl/tile_sched_ctrl_if.sv
// Host/output-stage handshake bundle for the tile scheduler.
// The scheduler connects through the slave modport; the driving side uses master.
interface tile_sched_ctrl_if #(
  parameter int ARR     = 4,
  parameter int DIM_W   = 6,
  parameter int DW      = 8,
  parameter int IDX_W   = DIM_W,
  parameter int OADDR_W = 2*IDX_W,
  parameter int PAD_W   = $clog2(ARR*DW+1)
);
  logic               start;
  logic               abort;
  logic [DIM_W-1:0]   dim_m;
  logic [DIM_W-1:0]   dim_n;
  logic [DIM_W-1:0]   dim_t;
  logic               tile_done;
  logic               load_i;
  logic               load_w;
  logic               calc_en;
  logic               acc_first;
  logic               busy;
  logic               done;
  logic               err;
  logic [IDX_W-1:0]   m_idx;
  logic [IDX_W-1:0]   n_idx;
  logic [IDX_W-1:0]   t_idx;
  logic [OADDR_W-1:0] o_addr;
  logic [PAD_W-1:0]   pad_sh;

  modport master (
    output start, abort, dim_m, dim_n, dim_t, tile_done,
    input  load_i, load_w, calc_en, acc_first, busy, done, err,
    input  m_idx, n_idx, t_idx, o_addr, pad_sh
  );

  modport slave (
    input  start, abort, dim_m, dim_n, dim_t, tile_done,
    output load_i, load_w, calc_en, acc_first, busy, done, err,
    output m_idx, n_idx, t_idx, o_addr, pad_sh
  );
endinterface

// File: rtl/tile_sched_ctrl.sv
// Tile scheduler for an ARRxARR weight-stationary MAC array: walks t/n/m output tiles.
// Optional STALL_CNT_EN adds a saturating count of cycles spent waiting in DRAIN.
module tile_sched_ctrl #(
  parameter int ARR      = 4,
  parameter int DIM_W    = 6,
  parameter int DW       = 8,
  parameter int LOAD_CYC = ARR,
  parameter int CALC_CYC = ARR,
  parameter int IDX_W    = DIM_W,
  parameter int OADDR_W  = 2*IDX_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  tile_sched_ctrl_if.slave  bus
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PAD_W  = $clog2(ARR*DW+1);
  localparam int PH_MAX = (LOAD_CYC > CALC_CYC) ? LOAD_CYC : CALC_CYC;
  localparam int PH_W   = $clog2(PH_MAX+1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_BOTH = 3'd1;
  localparam logic [2:0] LOAD_I    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;
  localparam logic [2:0] FIN       = 3'd5;

  function automatic logic [DIM_W-1:0] tiles(input logic [DIM_W-1:0] d);
    logic [DIM_W:0] s;
    s = {1'b0, d} + (DIM_W+1)'(ARR-1);
    return DIM_W'(s / (DIM_W+1)'(ARR));
  endfunction

`ifdef STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [2:0]       state, state_nxt;
  logic [PH_W-1:0]  ph;
  logic [DIM_W-1:0] dm_r, dn_r, dt_r;
  logic [DIM_W-1:0] tm, tn, tt;
  logic [IDX_W-1:0] m_idx, n_idx, t_idx;
  logic [IDX_W-1:0] m_nxt, n_nxt, t_nxt;
  logic             dims_ok, accept, reject, tile_adv;
  logic             last_m, last_n, last_t;
  logic             err_r;
  int               rem, rem_n;

  assign tm = tiles(dm_r);
  assign tn = tiles(dn_r);
  assign tt = tiles(dt_r);

  always_comb begin
    dims_ok  = (bus.dim_m != '0) && (bus.dim_n != '0) && (bus.dim_t != '0);
    accept   = (state == IDLE) && bus.start && dims_ok && !bus.abort;
    reject   = (state == IDLE) && bus.start && !dims_ok && !bus.abort;
    last_m   = int'(m_idx) == int'(tm) - 1;
    last_n   = int'(n_idx) == int'(tn) - 1;
    last_t   = int'(t_idx) == int'(tt) - 1;
    tile_adv = (state == DRAIN) && bus.tile_done && !bus.abort;

    // m sweeps fastest so the resident W tile B(n,t) is reused across the column
    m_nxt = last_m ? '0 : m_idx + IDX_W'(1);
    n_nxt = n_idx;
    t_nxt = t_idx;
    if (last_m) begin
      n_nxt = last_n ? '0 : n_idx + IDX_W'(1);
      if (last_n) t_nxt = t_idx + IDX_W'(1);
    end

    state_nxt = state;
    case (state)
      IDLE:      if (bus.start && dims_ok) state_nxt = LOAD_BOTH;
      LOAD_BOTH,
      LOAD_I:    if (ph == PH_W'(LOAD_CYC-1)) state_nxt = RUN;
      RUN:       if (ph == PH_W'(CALC_CYC-1)) state_nxt = DRAIN;
      DRAIN: begin
        if (bus.tile_done) begin
          if (last_m && last_n && last_t) state_nxt = FIN;
          else                            state_nxt = (m_nxt == '0) ? LOAD_BOTH : LOAD_I;
        end
      end
      FIN:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      ph    <= '0;
      err_r <= 1'b0;
      dm_r  <= '0;
      dn_r  <= '0;
      dt_r  <= '0;
      m_idx <= '0;
      n_idx <= '0;
      t_idx <= '0;
    end else begin
      state <= state_nxt;
      ph    <= (state_nxt != state) ? '0 : ph + PH_W'(1);
      err_r <= reject;
      if (accept) begin
        dm_r  <= bus.dim_m;
        dn_r  <= bus.dim_n;
        dt_r  <= bus.dim_t;
        m_idx <= '0;
        n_idx <= '0;
        t_idx <= '0;
      end else if (tile_adv && state_nxt != FIN) begin
        m_idx <= m_nxt;
        n_idx <= n_nxt;
        t_idx <= t_nxt;
      end
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                stall_cnt <= '0;
    else if (accept)          stall_cnt <= '0;
    else if (state == DRAIN)  stall_cnt <= sat_inc16(stall_cnt);
  end
`endif

  // Remaining depth can exceed ARR on non-final slices; treat that (and idle zero) as a full slice
  always_comb begin
    rem   = int'(dn_r) - int'(n_idx) * ARR;
    rem_n = (rem > 0 && rem < ARR) ? rem : ARR;
  end

  assign bus.load_i    = (state == LOAD_BOTH) || (state == LOAD_I);
  assign bus.load_w    = (state == LOAD_BOTH);
  assign bus.calc_en   = (state == RUN);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.err       = err_r;
  assign bus.acc_first = bus.busy && (n_idx == '0);
  assign bus.pad_sh    = bus.busy ? PAD_W'((ARR - rem_n) * DW) : '0;
  assign bus.m_idx     = m_idx;
  assign bus.n_idx     = n_idx;
  assign bus.t_idx     = t_idx;
  assign bus.o_addr    = OADDR_W'(int'(m_idx) * int'(tt) + int'(t_idx));

endmodule

// File: tb/tb_tile_sched_ctrl.sv
// Self-checking bench for tile_sched_ctrl: directed and random jobs against a tile-list model.
module tb_tile_sched_ctrl;
  localparam int A = 4;
  localparam int L = 4;
  localparam int C = 4;

  logic CLK = 1'b0;
  logic RSTN;
  int   total = 0;
  int   fails = 0;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 CLK = ~CLK;

  tile_sched_ctrl_if bus ();

  tile_sched_ctrl dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .bus       (bus)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected {load_i, load_w, calc_en, busy, done, err}
  task automatic chk_ctl(input string tag, input logic [5:0] e);
    chk(tag, 32'({bus.load_i, bus.load_w, bus.calc_en, bus.busy, bus.done, bus.err}), 32'(e));
  endtask

  task automatic chk_pos(input string tag, input int m, input int n, input int t, input int oa);
    chk({tag, "_idx"}, 32'({bus.m_idx, bus.n_idx, bus.t_idx}), 32'({6'(m), 6'(n), 6'(t)}));
    chk({tag, "_oaddr"}, 32'(bus.o_addr), 32'(oa));
  endtask

  task automatic chk_tile(input string tag, input int m, input int n, input int t,
                          input int acc, input int pad, input int oa);
    chk_pos(tag, m, n, t, oa);
    chk({tag, "_acc"}, 32'(bus.acc_first), 32'(acc));
    chk({tag, "_pad"}, 32'(bus.pad_sh), 32'(pad));
  endtask

  task automatic do_stop(input int kind);
    if (kind == 1) begin
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk_ctl("abort_next", 6'b000000);
      tick();
      chk_ctl("abort_quiet", 6'b000000);
    end else begin
      #2;
      RSTN = 1'b0;
      #1;
      chk_ctl("rst_async", 6'b000000);
      chk_tile("rst_async", 0, 0, 0, 0, 0, 0);
`ifdef STALL_CNT_EN
      chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
      #3;
      RSTN = 1'b1;
      tick();
      chk_ctl("rst_release", 6'b000000);
    end
  endtask

  // Runs one job; stop_kind 1 = abort, 2 = reset at (stop_tile, stop_phase 0 load/1 run, stop_cyc)
  task automatic run_job(input int M, input int N, input int T, input int dfix,
                         input int stop_tile, input int stop_phase, input int stop_cyc,
                         input int stop_kind, input bit start_busy, input bit run_tdone);
    int tmc, tnc, ttc, k, stall, d, rem, rn, pad, oa;
    tmc = (M + A - 1) / A;
    tnc = (N + A - 1) / A;
    ttc = (T + A - 1) / A;
    k = 0;
    stall = 0;
    bus.dim_m = 6'(M);
    bus.dim_n = 6'(N);
    bus.dim_t = 6'(T);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.dim_m = 6'($urandom);
    bus.dim_n = 6'($urandom);
    bus.dim_t = 6'($urandom);
    for (int t = 0; t < ttc; t++) begin
      for (int n = 0; n < tnc; n++) begin
        for (int m = 0; m < tmc; m++) begin
          rem = N - n * A;
          rn  = (rem < A) ? rem : A;
          pad = (A - rn) * 8;
          oa  = m * ttc + t;
          for (int c = 0; c < L; c++) begin
            chk_ctl("load", (m == 0) ? 6'b110100 : 6'b100100);
            chk_tile("load", m, n, t, (n == 0) ? 1 : 0, pad, oa);
            if (stop_kind != 0 && k == stop_tile && stop_phase == 0 && c == stop_cyc) begin
              do_stop(stop_kind);
              return;
            end
            if (start_busy && k == 1 && c == 0) begin
              bus.dim_m = 6'd1;
              bus.dim_n = 6'd1;
              bus.dim_t = 6'd1;
              bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
          end
          for (int c = 0; c < C; c++) begin
            chk_ctl("run", 6'b001100);
            chk_tile("run", m, n, t, (n == 0) ? 1 : 0, pad, oa);
            if (stop_kind != 0 && k == stop_tile && stop_phase == 1 && c == stop_cyc) begin
              do_stop(stop_kind);
              return;
            end
            bus.tile_done = run_tdone && (c == C - 1);
            tick();
            bus.tile_done = 1'b0;
          end
          d = (dfix < 0) ? int'($urandom_range(0, 3)) : dfix;
          for (int j = 0; j <= d; j++) begin
            chk_ctl("drain", 6'b000100);
            chk_tile("drain", m, n, t, (n == 0) ? 1 : 0, pad, oa);
            bus.tile_done = (j == d);
            tick();
            stall++;
          end
          bus.tile_done = 1'b0;
          k++;
        end
      end
    end
    chk_ctl("fin", 6'b000110);
    chk_pos("fin", tmc - 1, tnc - 1, ttc - 1, (tmc - 1) * ttc + ttc - 1);
    tick();
    chk_ctl("idle_after", 6'b000000);
    chk_pos("idle_hold", tmc - 1, tnc - 1, ttc - 1, (tmc - 1) * ttc + ttc - 1);
`ifdef STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(stall));
`endif
  endtask

  initial begin
    RSTN          = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.tile_done = 1'b0;
    bus.dim_m     = '0;
    bus.dim_n     = '0;
    bus.dim_t     = '0;
    tick();
    tick();
    chk_ctl("reset", 6'b000000);
    chk_tile("reset", 0, 0, 0, 0, 0, 0);
    RSTN = 1'b1;
    tick();
    chk_ctl("reset_rel", 6'b000000);

    run_job(4, 4, 4, 2, -1, 0, 0, 0, 1'b0, 1'b0);
    run_job(8, 5, 8, 0, -1, 0, 0, 0, 1'b0, 1'b0);

    bus.dim_m = 6'd4;
    bus.dim_n = 6'd0;
    bus.dim_t = 6'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_ctl("err_pulse", 6'b000001);
    tick();
    chk_ctl("err_clear", 6'b000000);
    tick();
    chk_ctl("err_no_load", 6'b000000);

    run_job(4, 4, 4, 9, -1, 0, 0, 0, 1'b0, 1'b1);

    run_job(8, 5, 8, 0, 1, 1, 1, 1, 1'b0, 1'b0);
    run_job(8, 5, 8, 0, -1, 0, 0, 0, 1'b0, 1'b0);

    run_job(8, 5, 8, 1, 1, 0, 1, 2, 1'b1, 1'b0);
    run_job(5, 9, 3, -1, -1, 0, 0, 0, 1'b0, 1'b0);

    run_job(1, 63, 1, 0, -1, 0, 0, 0, 1'b0, 1'b0);
    run_job(63, 2, 1, 0, -1, 0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      run_job(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), -1, -1, 0, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/tile_sched_ctrl.md
Name: tile_sched_ctrl

Overview:
Parametrised tile scheduler for the ARR×ARR weight-stationary MAC array. It latches runtime matrix dimensions M (rows of I), N (depth), T (columns of W) and walks every output tile. Per tile it sequences the I/W buffer loads and the compute window, then waits for the output stage before moving on. Successor of the fixed 4×4, ≤8-dimension controller: any tile count, a tile_done handshake, accumulate flags, abort and error reporting.

Parameters:
ARR, 4, array edge; also the tile edge.
DIM_W, 6, width of each M/N/T dimension input (max dimension 2^DIM_W-1).
DW, 8, operand width in bits, used for the padding shift.
LOAD_CYC, ARR, cycles per load phase.
CALC_CYC, ARR, cycles per compute phase.
IDX_W, DIM_W, width of tile-index outputs.
OADDR_W, 2*IDX_W, width of the output tile address.

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
start  in  1  1-cycle request; sampled only in IDLE
abort  in  1  synchronous abort to IDLE
dim_m, dim_n, dim_t  in  DIM_W each  matrix dimensions
tile_done  in  1  output stage finished current tile (pulse)
load_i  out  1  I buffer load enable
load_w  out  1  W buffer load enable
calc_en  out  1  array compute enable
acc_first  out  1  current tile is first depth slice (overwrite, not accumulate)
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse, whole job finished
err  out  1  1-cycle pulse, start rejected (zero dimension)
m_idx, n_idx, t_idx  out  IDX_W each  current tile indices
o_addr  out  OADDR_W  m_idx*TT + t_idx
pad_sh  out  clog2(ARR*DW+1)  (ARR-rem_n)*DW

Behaviour:
- Reset RSTN, asynchronous, active-low; clock CLK. Reset forces state IDLE; all outputs 0; indices and dimension registers 0. Reset mid-job discards the job.
- Tile counts: TM=ceil(M/ARR), TN=ceil(N/ARR), TT=ceil(T/ARR). All are computed from the registered dimensions.
- start in IDLE with all dims nonzero: latch dims, clear indices, next state LOAD_BOTH.
- start in IDLE with any dim 0: err=1 for one cycle, stay IDLE.
- start outside IDLE is ignored.
- Loop order is t_idx (outer), n_idx (middle), m_idx (inner). W tile B(n,t) stays resident while m sweeps.
- Outputs are Moore, decoded from the registered state. A phase counter clears on every state change.
- LOAD_BOTH: load_i=load_w=1 for LOAD_CYC cycles, then RUN.
- LOAD_I: load_i=1 for LOAD_CYC cycles, then RUN.
- RUN: calc_en=1 for CALC_CYC cycles, then DRAIN.
- DRAIN: all enables 0; wait for tile_done.
- tile_done on a non-last tile: advance indices (m; on wrap n; on wrap t). Next state is LOAD_BOTH if the new m_idx==0, else LOAD_I.
- tile_done on the last tile (m=TM-1, n=TN-1, t=TT-1): next state FIN.
- FIN: done=1 for one cycle, then IDLE. Indices hold their final values until the next start.
- tile_done outside DRAIN is ignored, including tile_done in the last RUN cycle.
- abort in any state: next cycle IDLE, no done, enables drop. abort has priority over tile_done and start.
- acc_first = (n_idx==0). It is valid throughout the tile's LOAD/RUN/DRAIN.
- rem_n = min(ARR, N - n_idx*ARR), computed at full width with no truncation. pad_sh=(ARR-rem_n)*DW. It is 0 when N is a multiple of ARR or for a non-final depth slice.
- Index and address updates occur on the clock edge leaving DRAIN. They are stable for the whole following tile.

Optional Feature:
STALL_CNT_EN: when defined, adds output stall_cnt [15:0].
- stall_cnt counts cycles spent in DRAIN since the last accepted start and saturates at 16'hFFFF.
- It clears on accepted start and on reset, and holds in IDLE.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- ARR=4, M=N=T=4, start, tile_done 2 cycles after DRAIN entry: expect load_i/load_w high 4 cycles, calc_en 4 cycles, then done pulse; acc_first=1, pad_sh=0, o_addr=0.
- M=8, N=5, T=8 (TM=TN=TT=2, 8 tiles), tile_done immediate: expect load_w 4 times, at tiles (m,n,t)=(0,0,0),(0,1,0),(0,0,1),(0,1,1). Expect pad_sh=24 when n_idx=1, else 0. Expect acc_first=0 when n_idx=1. Expect o_addr sequence 0,2,0,2,1,3,1,3. Expect one done.
- dim_n=0 with start: expect err pulse, busy stays 0, no load.
- tile_done withheld 10 cycles in DRAIN, extra tile_done pulse during RUN: expect DRAIN held 10 cycles, the RUN pulse has no effect, stall_cnt=10 (STALL_CNT_EN).
- abort during second RUN of the M=8 job: expect busy 0 next cycle, no done. A subsequent start restarts at indices 0.
- start pulsed while busy, and RSTN asserted mid-LOAD_I: expect start ignored; reset forces all outputs 0 asynchronously.
